ifu_fsm: RTL and testbench
==========================

# ifu_fsm

Fetch-control state machine for the instruction fetch unit. It drives the AXI4 read-address and read-data handshakes for one instruction per fetch and issues the write enables for the IFU PC and instruction registers. It hands the fetched instruction downstream to the IDU with a valid/ready handshake and waits for the WBU's next-PC commit before starting the next fetch. It is also the IFU's error and performance-counter point.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clock`, in, 1: the single clock; rising edge.
- `reset`, in, 1: asynchronous, active-low reset (`RESET_ENABLE` = 0).
- `valid_pre_i`, in, 1: WBU has a committed next PC on `next_pc`.
- `ready_pre_o`, out, 1: IFU accepts the next PC.
- `valid_post_o`, out, 1: fetched instruction is valid toward the IDU.
- `ready_post_i`, in, 1: IDU accepts the instruction.
- `arvalid_o`, out, 1: AXI4 AR valid.
- `arready_i`, in, 1: AXI4 AR ready.
- `rvalid_i`, in, 1: AXI4 R valid.
- `rready_o`, out, 1: AXI4 R ready.
- `rresp_i`, in, 2: AXI4 R response.
- `pc_we_o`, out, 1: PC/snpc register write enable (`WRITE_ENABLE` = 1).
- `rdata_we_o`, out, 1: instruction register write enable.
- `fetch_err_o`, out, 1: sticky flag; set on any non-OKAY `rresp_i`.
- `fetch_cnt_o`, out, `CNT_W`: count of completed R beats.
- `stall_cnt_o`, out, `CNT_W`: cycles spent waiting on AXI.

## Operation
States and transitions:
- S_IDLE → S_AR unconditionally. S_IDLE is the reset state.
- S_AR: `arvalid_o` = 1. Move to S_R on `arready_i`.
- S_R: `rready_o` = 1. Move to S_ISSUE on `rvalid_i`.
- S_ISSUE: `valid_post_o` = 1. Move to S_WAIT on `ready_post_i`.
- S_WAIT: `ready_pre_o` = 1. Move to S_AR on `valid_pre_i`.

Output decode:
- `arvalid_o`, `rready_o`, `valid_post_o` and `ready_pre_o` are Moore outputs decoded from the state register only.
- `rdata_we_o` = (S_R & `rvalid_i`). This is a Mealy output; the instruction register captures `rdata` on the same edge as the handshake.
- `pc_we_o` = (S_WAIT & `valid_pre_i`). This is a Mealy output; PC and snpc update on the same edge the FSM enters S_AR, so the AR address is the new PC.

Error flag:
- On an R handshake with `rresp_i` ≠ 2'b00, `fetch_err_o` is set and stays set until reset.
- The fetch still completes normally: data is written and passed downstream.

Counters:
- `fetch_cnt_o` increments on every R handshake.
- `stall_cnt_o` increments in every cycle spent in S_AR without `arready_i`, or in S_R without `rvalid_i`.
- Both counters wrap from all-ones to 0 with no saturation.

## Timing
- Reset is asynchronous: while `reset` = 0, the state is S_IDLE and every output is 0, including both counters and `fetch_err_o`.
- The first `arvalid_o` rises in the 2nd cycle after reset deasserts (one cycle in S_IDLE).
- Minimum fetch loop is 4 cycles (AR, R, ISSUE, WAIT), reached when `arready_i`, `rvalid_i`, `ready_post_i` and `valid_pre_i` are all 1 on entry to each state.
- `arready_i` high in the same cycle `arvalid_o` first rises completes the AR handshake at that edge.
- `rvalid_i` asserted outside S_R is ignored: `rready_o` is 0 and no write or count occurs.
- In S_ISSUE, `valid_pre_i` is ignored. In S_WAIT, `ready_post_i` is ignored.
- `valid_post_o` stays high until `ready_post_i`. Handshake outputs are never withdrawn before their handshake completes.
- Reset asserted mid-transaction aborts the transaction immediately, and all outputs return to 0. The in-flight AXI beat is abandoned; the slave must tolerate this.
- AXI signals are single-beat only (arlen = 0, driven elsewhere). R-channel `rlast` is not examined.

## Structure
- State encodings (S_IDLE, S_AR, S_R, S_ISSUE, S_WAIT; 3 bits) live in the shared defines alongside `RESET_ENABLE`, `WRITE_ENABLE` and the AXI bus-width macros.
- Add `AXI4_RESP_OKAY` = 2'b00 to the shared defines.
- The two counters are built from one parameterised sub-module, `ifu_perf_cnt`, with ports `clock`, `reset`, `inc_i` and `cnt_o`, instantiated twice.
- State register, next-state logic and output decode stay in `ifu_fsm`.

## Test plan
- Reset release, all handshake inputs tied 1 → `arvalid_o` rises in cycle 2 after release. `rdata_we_o` pulses in cycle 3 and `pc_we_o` in cycle 5. Steady-state period is 4 cycles.
- `arready_i` delayed 3 cycles, `rvalid_i` delayed 2 cycles → `arvalid_o` held for 4 cycles and `rready_o` for 3 cycles. `stall_cnt_o` = 5 and `fetch_cnt_o` = 1.
- `ready_post_i` low for 6 cycles → `valid_post_o` held for 7 cycles. No `pc_we_o` pulse and no new `arvalid_o` during that time.
- `rresp_i` = 2'b10 on the 2nd fetch → `fetch_err_o` rises after that edge and stays 1 across 3 later OKAY fetches. `rdata_we_o` still pulses each fetch.
- `reset` pulled low while in S_R with `rvalid_i` = 1 → all outputs are 0 immediately, with no `rdata_we_o` pulse. After release, the sequence restarts as in the first scenario.
- Counter preloaded to all-ones (force, `CNT_W` = 4 build), then one fetch → `fetch_cnt_o` reads 0.

Source files
------------

// File: rtl/ifu_fsm_pkg.sv
// Shared definitions for the IFU fetch controller: reset/write polarities,
// AXI response codes and the fetch-state encoding.
package ifu_fsm_pkg;

  localparam logic RESET_ENABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_RESP_W = 2;

  localparam logic [AXI_RESP_W-1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI4_RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_W-1:0] AXI4_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] AXI4_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_R     = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4
  } ifu_state_e;

  // EXOKAY is not meaningful for an instruction fetch, so anything but OKAY is an error.
  function automatic logic resp_is_err(input logic [AXI_RESP_W-1:0] resp);
    return resp != AXI4_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// Free-running wrap-around event counter used for the IFU performance counters.
module ifu_perf_cnt
  import ifu_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ifu_fsm.sv
// Fetch-control FSM: AXI AR/R handshakes, IDU/WBU valid-ready handshakes,
// register write enables, sticky fetch error and performance counters.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   S_IDLE  | reset state, one cycle before the first fetch
//   S_AR    | address phase, arvalid high until arready
//   S_R     | data phase, rready high until rvalid
//   S_ISSUE | instruction offered to IDU until ready_post
//   S_WAIT  | waiting for WBU next-PC commit (valid_pre)
module ifu_fsm
  import ifu_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_pre_i,
  output logic                  ready_pre_o,
  output logic                  valid_post_o,
  input  logic                  ready_post_i,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [AXI_RESP_W-1:0] rresp_i,
  output logic                  pc_we_o,
  output logic                  rdata_we_o,
  output logic                  fetch_err_o,
  output logic [CNT_W-1:0]      fetch_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  ifu_state_e state;
  logic       r_hs;
  logic       pre_hs;
  logic       stall;

  assign r_hs   = (state == S_R) && rvalid_i;
  assign pre_hs = (state == S_WAIT) && valid_pre_i;
  assign stall  = ((state == S_AR) && !arready_i) || ((state == S_R) && !rvalid_i);

  // Write enables are Mealy so registers capture on the handshake edge itself.
  assign rdata_we_o = r_hs ? WRITE_ENABLE : ~WRITE_ENABLE;
  assign pc_we_o    = pre_hs ? WRITE_ENABLE : ~WRITE_ENABLE;

  // Handshake outputs are registered alongside the state so they equal a decode of it.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state        <= S_IDLE;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      valid_post_o <= 1'b0;
      ready_pre_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_AR;
          arvalid_o <= 1'b1;
        end
        S_AR: begin
          if (arready_i) begin
            state     <= S_R;
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
          end
        end
        S_R: begin
          if (rvalid_i) begin
            state        <= S_ISSUE;
            rready_o     <= 1'b0;
            valid_post_o <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (ready_post_i) begin
            state        <= S_WAIT;
            valid_post_o <= 1'b0;
            ready_pre_o  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (valid_pre_i) begin
            state       <= S_AR;
            ready_pre_o <= 1'b0;
            arvalid_o   <= 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          arvalid_o    <= 1'b0;
          rready_o     <= 1'b0;
          valid_post_o <= 1'b0;
          ready_pre_o  <= 1'b0;
        end
      endcase
    end
  end

  // Error is only recorded; the faulty beat is still written and issued downstream.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      fetch_err_o <= 1'b0;
    end else if (r_hs && resp_is_err(rresp_i)) begin
      fetch_err_o <= 1'b1;
    end
  end

  ifu_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_fetch_cnt (
    .clock (clock),
    .reset (reset),
    .inc_i (r_hs),
    .cnt_o (fetch_cnt_o)
  );

  ifu_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc_i (stall),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_ifu_fsm.sv
// Self-checking bench for ifu_fsm (4-bit counters so wrap-around is reachable).
module tb_ifu_fsm;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             valid_pre_i = 1'b0;
  logic             ready_post_i = 1'b0;
  logic             arready_i = 1'b0;
  logic             rvalid_i = 1'b0;
  logic [1:0]       rresp_i = 2'b00;
  logic             ready_pre_o, valid_post_o, arvalid_o, rready_o;
  logic             pc_we_o, rdata_we_o, fetch_err_o;
  logic [CNT_W-1:0] fetch_cnt_o, stall_cnt_o;

  logic [5:0] obs;
  assign obs = {arvalid_o, rready_o, valid_post_o, ready_pre_o, rdata_we_o, pc_we_o};

  int checks = 0;
  int failures = 0;

  logic [CNT_W-1:0] exp_cnt_q[$];
  logic             exp_err_q[$];
  logic [CNT_W-1:0] exp_fetch;
  logic             exp_err;

  ifu_fsm #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .valid_pre_i  (valid_pre_i),
    .ready_pre_o  (ready_pre_o),
    .valid_post_o (valid_post_o),
    .ready_post_i (ready_post_i),
    .arvalid_o    (arvalid_o),
    .arready_i    (arready_i),
    .rvalid_i     (rvalid_i),
    .rready_o     (rready_o),
    .rresp_i      (rresp_i),
    .pc_we_o      (pc_we_o),
    .rdata_we_o   (rdata_we_o),
    .fetch_err_o  (fetch_err_o),
    .fetch_cnt_o  (fetch_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset = 1'b0;
    arready_i = 1'b0; rvalid_i = 1'b0; ready_post_i = 1'b0; valid_pre_i = 1'b0;
    rresp_i = 2'b00;
    repeat (2) @(negedge clock);
    exp_cnt_q.delete();
    exp_err_q.delete();
    exp_fetch = '0;
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    arready_i = 1'b1; rvalid_i = 1'b1; ready_post_i = 1'b1; valid_pre_i = 1'b1;
    rresp_i = 2'b10;
    #2 reset = 1'b0;
    @(negedge clock); #1;
    checks++; if (obs !== 6'b0) begin failures++; $display("FAIL reset_outputs: got %b expected %b", obs, 6'b0); end
    checks++; if (fetch_cnt_o !== '0) begin failures++; $display("FAIL reset_fetch_cnt: got %0d expected 0", fetch_cnt_o); end
    checks++; if (stall_cnt_o !== '0) begin failures++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt_o); end
    checks++; if (fetch_err_o !== 1'b0) begin failures++; $display("FAIL reset_fetch_err: got %b expected 0", fetch_err_o); end
  endtask

  // All handshakes tied high: 4-cycle loop, 17 fetches so the 4-bit fetch counter wraps.
  task automatic test_min_loop();
    int st;
    logic [5:0] exp_o;
    apply_reset();
    arready_i = 1'b1; rvalid_i = 1'b1; ready_post_i = 1'b1; valid_pre_i = 1'b1;
    reset = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      st = (c == 1) ? -1 : (c - 2) % 4;
      exp_o = {st == 0, st == 1, st == 2, st == 3, st == 1, st == 3};
      checks++;
      if (obs !== exp_o) begin
        failures++; $display("FAIL min_loop_outputs cycle %0d: got %b expected %b", c, obs, exp_o);
      end
      if (exp_cnt_q.size() > 0) begin
        logic [CNT_W-1:0] ec;
        logic ee;
        ec = exp_cnt_q.pop_front();
        ee = exp_err_q.pop_front();
        checks++; if (fetch_cnt_o !== ec) begin failures++; $display("FAIL min_loop_fetch_cnt cycle %0d: got %0d expected %0d", c, fetch_cnt_o, ec); end
        checks++; if (fetch_err_o !== ee) begin failures++; $display("FAIL min_loop_fetch_err cycle %0d: got %b expected %b", c, fetch_err_o, ee); end
      end
      if (st == 1) begin
        exp_fetch = exp_fetch + 1'b1;
        exp_cnt_q.push_back(exp_fetch);
        exp_err_q.push_back(exp_err);
      end
    end
    checks++; if (stall_cnt_o !== '0) begin failures++; $display("FAIL min_loop_stall_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

  // arready on the 4th AR cycle, rvalid on the 3rd R cycle; rvalid held high outside S_R.
  task automatic test_axi_stall();
    int ar_seen = 0;
    int r_seen = 0;
    bit done = 0;
    bit beat;
    apply_reset();
    ready_post_i = 1'b1; valid_pre_i = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clock);
      arready_i = arvalid_o && (ar_seen == 3);
      beat = rready_o && (r_seen == 2);
      rvalid_i = rready_o ? beat : 1'b1;
      #1;
      if (exp_cnt_q.size() > 0) begin
        logic [CNT_W-1:0] ec;
        logic ee;
        ec = exp_cnt_q.pop_front();
        ee = exp_err_q.pop_front();
        checks++; if (fetch_cnt_o !== ec) begin failures++; $display("FAIL stall_fetch_cnt: got %0d expected %0d", fetch_cnt_o, ec); end
        checks++; if (fetch_err_o !== ee) begin failures++; $display("FAIL stall_fetch_err: got %b expected %b", fetch_err_o, ee); end
      end
      checks++;
      if (rdata_we_o !== beat) begin
        failures++; $display("FAIL stall_rdata_we step %0d: got %b expected %b", i, rdata_we_o, beat);
      end
      if (arvalid_o) ar_seen++;
      if (rready_o) r_seen++;
      if (beat) begin
        exp_fetch = exp_fetch + 1'b1;
        exp_cnt_q.push_back(exp_fetch);
        exp_err_q.push_back(exp_err);
      end
      if (valid_post_o) begin done = 1; break; end
    end
    checks++; if (!done) begin failures++; $display("FAIL stall_timeout: got no valid_post expected valid_post within 40 cycles"); end
    checks++; if (ar_seen != 4) begin failures++; $display("FAIL stall_arvalid_len: got %0d expected 4", ar_seen); end
    checks++; if (r_seen != 3) begin failures++; $display("FAIL stall_rready_len: got %0d expected 3", r_seen); end
    checks++; if (stall_cnt_o !== 4'd5) begin failures++; $display("FAIL stall_cnt: got %0d expected 5", stall_cnt_o); end
  endtask

  // ready_post low for 6 cycles of valid_post; valid_pre held high the whole time.
  task automatic test_issue_hold();
    int vp_cnt = 0;
    bit done = 0;
    apply_reset();
    arready_i = 1'b1; rvalid_i = 1'b1; valid_pre_i = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clock);
      ready_post_i = valid_post_o && (vp_cnt == 6);
      #1;
      if (valid_post_o) begin
        vp_cnt++;
        checks++;
        if (pc_we_o !== 1'b0 || arvalid_o !== 1'b0) begin
          failures++; $display("FAIL issue_hold_quiet step %0d: got pc_we=%b arvalid=%b expected 0/0", i, pc_we_o, arvalid_o);
        end
      end else if (vp_cnt > 0) begin
        checks++;
        if (ready_pre_o !== 1'b1 || pc_we_o !== 1'b1) begin
          failures++; $display("FAIL issue_hold_wait: got ready_pre=%b pc_we=%b expected 1/1", ready_pre_o, pc_we_o);
        end
        done = 1;
        break;
      end
    end
    checks++; if (!done) begin failures++; $display("FAIL issue_hold_timeout: got no S_WAIT expected S_WAIT within 40 cycles"); end
    checks++; if (vp_cnt != 7) begin failures++; $display("FAIL issue_hold_len: got %0d expected 7", vp_cnt); end
  endtask

  // SLVERR on the 2nd of 5 fetches; flag must stick through the following OKAY fetches.
  task automatic test_error();
    int fidx = 0;
    bit done = 0;
    apply_reset();
    arready_i = 1'b1; rvalid_i = 1'b1; ready_post_i = 1'b1; valid_pre_i = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clock);
      rresp_i = (rready_o && fidx == 1) ? 2'b10 : 2'b00;
      #1;
      if (exp_cnt_q.size() > 0) begin
        logic [CNT_W-1:0] ec;
        logic ee;
        ec = exp_cnt_q.pop_front();
        ee = exp_err_q.pop_front();
        checks++; if (fetch_cnt_o !== ec) begin failures++; $display("FAIL err_fetch_cnt: got %0d expected %0d", fetch_cnt_o, ec); end
        checks++; if (fetch_err_o !== ee) begin failures++; $display("FAIL err_flag: got %b expected %b", fetch_err_o, ee); end
      end
      if (rready_o) begin
        checks++; if (rdata_we_o !== 1'b1) begin failures++; $display("FAIL err_rdata_we fetch %0d: got %b expected 1", fidx, rdata_we_o); end
        if (fidx == 1) begin
          checks++; if (fetch_err_o !== 1'b0) begin failures++; $display("FAIL err_early: got %b expected 0", fetch_err_o); end
        end
        fidx++;
        exp_fetch = exp_fetch + 1'b1;
        exp_err = exp_err | (rresp_i != 2'b00);
        exp_cnt_q.push_back(exp_fetch);
        exp_err_q.push_back(exp_err);
      end
      if (fidx == 5 && exp_cnt_q.size() == 0) begin done = 1; break; end
    end
    checks++; if (!done) begin failures++; $display("FAIL err_timeout: got %0d fetches expected 5", fidx); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    arready_i = 1'b1; rvalid_i = 1'b1; ready_post_i = 1'b1; valid_pre_i = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (rready_o !== 1'b1 || rdata_we_o !== 1'b1) begin failures++; $display("FAIL mid_precond: got rready=%b rdata_we=%b expected 1/1", rready_o, rdata_we_o); end
    #1 reset = 1'b0;
    #1;
    checks++; if (obs !== 6'b0) begin failures++; $display("FAIL mid_outputs: got %b expected %b", obs, 6'b0); end
    @(posedge clock); #1;
    checks++; if (fetch_cnt_o !== '0) begin failures++; $display("FAIL mid_fetch_cnt: got %0d expected 0", fetch_cnt_o); end
    checks++; if (obs !== 6'b0) begin failures++; $display("FAIL mid_hold: got %b expected %b", obs, 6'b0); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (obs !== 6'b0) begin failures++; $display("FAIL mid_restart_idle: got %b expected %b", obs, 6'b0); end
    @(negedge clock); #1;
    checks++; if (obs !== 6'b100000) begin failures++; $display("FAIL mid_restart_ar: got %b expected %b", obs, 6'b100000); end
    @(negedge clock); #1;
    checks++; if (obs !== 6'b010010) begin failures++; $display("FAIL mid_restart_r: got %b expected %b", obs, 6'b010010); end
    @(negedge clock); #1;
    checks++; if (fetch_cnt_o !== 4'd1) begin failures++; $display("FAIL mid_restart_cnt: got %0d expected 1", fetch_cnt_o); end
  endtask

  // arready held low: 21 AR cycles so the 4-bit stall counter wraps.
  task automatic test_stall_wrap();
    logic [CNT_W-1:0] es;
    apply_reset();
    ready_post_i = 1'b1; valid_pre_i = 1'b1;
    reset = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      es = (c < 2) ? '0 : CNT_W'(c - 2);
      checks++;
      if (stall_cnt_o !== es) begin
        failures++; $display("FAIL stall_wrap cycle %0d: got %0d expected %0d", c, stall_cnt_o, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_min_loop();
    test_axi_stall();
    test_issue_hold();
    test_error();
    test_reset_mid();
    test_stall_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
